pwm_duty_ramp: RTL

Command stage directly upstream of `pwm_core`: accepts new duty/period settings over a valid/ready handshake and holds them in a one-deep shadow register. It drives `pwm_core`'s `duty` and `period` inputs and applies updates only on `pwm_core`'s `rollover` pulse, so no PWM cycle is ever truncated. Optionally, it slew-limits duty changes by a fixed step per PWM cycle.

---
 rtl/pwm_pkg.sv | 14 +
 rtl/pwm_slew_step.sv | 28 ++
 rtl/pwm_duty_ramp.sv | 126 ++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM command/ramp blocks.
package pwm_pkg;

    localparam int unsigned PWM_WIDTH      = 8;
    localparam int unsigned PWM_RST_DUTY   = 0;
    localparam int unsigned PWM_RST_PERIOD = 255;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        RAMP    = 2'd2
    } state_t;

endpackage

// File: rtl/pwm_slew_step.sv
// Next duty value moving cur toward target by at most STEP, compare-before-add so it never wraps.
module pwm_slew_step
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = PWM_WIDTH,
    parameter int unsigned STEP  = 1
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] next_duty_c
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    always_comb begin
        next_duty_c = target;
        if (target > cur) begin
            if ((target - cur) > STEP_W) begin
                next_duty_c = cur + STEP_W;
            end
        end else if (cur > target) begin
            if ((cur - target) > STEP_W) begin
                next_duty_c = cur - STEP_W;
            end
        end
    end

endmodule

// File: rtl/pwm_duty_ramp.sv
// Command stage for pwm_core: shadows one duty/period command and applies it only on rollover.
// Define PWM_RAMP_EN to slew-limit duty changes by STEP per PWM cycle.
module pwm_duty_ramp
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH      = PWM_WIDTH,
    parameter int unsigned STEP       = 1,
    parameter int unsigned RST_DUTY   = PWM_RST_DUTY,
    parameter int unsigned RST_PERIOD = PWM_RST_PERIOD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_duty,
    input  logic [WIDTH-1:0] cmd_period,
    input  logic             rollover,
    output logic [WIDTH-1:0] duty_out,
    output logic [WIDTH-1:0] period_out,
    output logic             busy,
    output logic             ramp_done
);

    localparam int unsigned MAX_STEP = (1 << WIDTH) - 1;
`ifdef PWM_RAMP_EN
    localparam int unsigned STEP_EFF = STEP;
`else
    // An all-ones step always lands on the target in a single rollover.
    localparam int unsigned STEP_EFF = STEP | MAX_STEP;
`endif

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] hold_duty;
    logic [WIDTH-1:0] hold_period;
    logic [WIDTH-1:0] target;
    logic             hold_full;
    logic             accept;
    logic             load;
    logic [WIDTH-1:0] eff_target;
    logic [WIDTH-1:0] step_duty;
    logic [WIDTH-1:0] duty_next;
    logic [WIDTH-1:0] period_next;
    logic [WIDTH-1:0] target_next;
    logic             ramp_done_next;

    assign hold_full  = (state == PENDING);
    assign cmd_ready  = ~hold_full;
    assign busy       = hold_full | (duty_out != target);
    assign accept     = cmd_valid & ~hold_full;
    assign load       = rollover & hold_full;
    assign eff_target = load ? hold_duty : target;

    pwm_slew_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP_EFF)
    ) u_slew (
        .cur         (duty_out),
        .target      (eff_target),
        .next_duty_c (step_duty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_next     = state;
        duty_next      = duty_out;
        period_next    = period_out;
        target_next    = target;
        ramp_done_next = 1'b0;

        if (rollover) begin
            duty_next      = step_duty;
            ramp_done_next = (step_duty == eff_target) && (load || (duty_out != eff_target));
        end
        if (load) begin
            period_next = hold_period;
            target_next = hold_duty;
        end

        case (state)
            IDLE: begin
                if (accept) state_next = PENDING;
            end
            PENDING: begin
                if (rollover) state_next = (step_duty == eff_target) ? IDLE : RAMP;
            end
            RAMP: begin
                if (accept) begin
                    state_next = PENDING;
                end else if (rollover && (step_duty == target)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_out    <= WIDTH'(RST_DUTY);
            period_out  <= WIDTH'(RST_PERIOD);
            target      <= WIDTH'(RST_DUTY);
            ramp_done   <= 1'b0;
            hold_duty   <= '0;
            hold_period <= '0;
        end else begin
            duty_out   <= duty_next;
            period_out <= period_next;
            target     <= target_next;
            ramp_done  <= ramp_done_next;
            if (accept) begin
                hold_duty   <= cmd_duty;
                hold_period <= cmd_period;
            end
        end
    end

endmodule
